// File: rtl/alu_writeback_stage_if.sv
// rtl/alu_writeback_stage_if.sv - ALU-to-writeback and writeback-to-register-file handshake bundles
interface alu_wb_in_if;
    logic        InValid;
    logic        InReady;
    logic [31:0] ALUResult;
    logic        Carry;
    logic        Zero;
    logic        Negative;
    logic        Overflow;
    logic [4:0]  RdAddr;
    logic        SetFlags;
    logic [3:0]  CondCode;

    modport master (output InValid, ALUResult, Carry, Zero, Negative, Overflow,
                    RdAddr, SetFlags, CondCode, input InReady);
    modport slave  (input InValid, ALUResult, Carry, Zero, Negative, Overflow,
                    RdAddr, SetFlags, CondCode, output InReady);
endinterface

interface alu_wb_out_if;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] WbResult;
    logic [4:0]  WbAddr;
    logic        WbEnable;

    modport master (output OutValid, WbResult, WbAddr, WbEnable, input OutReady);
    modport slave  (input OutValid, WbResult, WbAddr, WbEnable, output OutReady);
endinterface

// File: rtl/alu_writeback_stage.sv
// rtl/alu_writeback_stage.sv - 2-entry ALU writeback queue with NZCV condition commit
// Optional feature macro: ALU_WB_COND_EN (condition evaluation and suppressed-op counter).
module alu_writeback_stage #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_wb_in_if.slave       in_if,
    alu_wb_out_if.master     out_if,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] SuppressCount
);
    localparam logic [1:0] FULL = 2'(DEPTH);

    logic [31:0] res_q  [2];
    logic [3:0]  nzcv_q [2];
    logic [4:0]  rd_q   [2];
    logic        setf_q [2];
    logic [1:0]  count;
    logic        head_ptr;
    logic        tail_ptr;
    logic        pass;
    logic        enq;
    logic        deq;

    assign in_if.InReady   = rst_n & (count != FULL);
    assign out_if.OutValid = (count != 2'd0);
    assign enq = in_if.InValid & in_if.InReady;
    assign deq = out_if.OutValid & out_if.OutReady;

    assign out_if.WbResult = out_if.OutValid ? res_q[head_ptr] : 32'd0;
    assign out_if.WbAddr   = out_if.OutValid ? rd_q[head_ptr]  : 5'd0;
    assign out_if.WbEnable = out_if.OutValid & pass;

`ifdef ALU_WB_COND_EN
    logic [3:0]       cond_q [2];
    logic [CNT_W-1:0] supp_q;

    // Condition sees only committed flags, so head and WbEnable stay stable until dequeue.
    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = Flags;
        pass = 1'b0;
        case (cond_q[head_ptr])
            4'd0:    pass = z;
            4'd1:    pass = !z;
            4'd2:    pass = c;
            4'd3:    pass = !c;
            4'd4:    pass = n;
            4'd5:    pass = !n;
            4'd6:    pass = v;
            4'd7:    pass = !v;
            4'd8:    pass = c & !z;
            4'd9:    pass = !c | z;
            4'd10:   pass = (n == v);
            4'd11:   pass = (n != v);
            4'd12:   pass = !z & (n == v);
            4'd13:   pass = z | (n != v);
            4'd14:   pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (enq) cond_q[tail_ptr] <= in_if.CondCode;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            supp_q <= '0;
        end else if (deq && !pass && supp_q != {CNT_W{1'b1}}) begin
            supp_q <= supp_q + CNT_W'(1);
        end
    end

    assign SuppressCount = supp_q;
`else
    logic unused_cond;
    assign unused_cond   = ^in_if.CondCode;
    assign pass          = 1'b1;
    assign SuppressCount = '0;
`endif

    always_ff @(posedge clk) begin
        if (enq) begin
            res_q[tail_ptr]  <= in_if.ALUResult;
            nzcv_q[tail_ptr] <= {in_if.Negative, in_if.Zero, in_if.Carry, in_if.Overflow};
            rd_q[tail_ptr]   <= in_if.RdAddr;
            setf_q[tail_ptr] <= in_if.SetFlags;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= 2'd0;
            head_ptr <= 1'b0;
            tail_ptr <= 1'b0;
            Flags    <= 4'b0000;
        end else begin
            if (enq) tail_ptr <= ~tail_ptr;
            if (deq) begin
                head_ptr <= ~head_ptr;
                if (pass && setf_q[head_ptr]) Flags <= nzcv_q[head_ptr];
            end
            case ({enq, deq})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_writeback_stage.sv
// tb/tb_alu_writeback_stage.sv - directed self-checking bench for alu_writeback_stage
module tb_alu_writeback_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  flags;
    logic [15:0] supp;
    int          vectors = 0;
    int          miscompares = 0;

`ifdef ALU_WB_COND_EN
    localparam bit COND = 1'b1;
`else
    localparam bit COND = 1'b0;
`endif

    alu_wb_in_if  in_if ();
    alu_wb_out_if out_if ();

    alu_writeback_stage #(.DEPTH(2), .CNT_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_if         (in_if),
        .out_if        (out_if),
        .Flags         (flags),
        .SuppressCount (supp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] r, input logic [4:0] a, input logic s,
                        input logic [3:0] cc, input logic [3:0] nzcv);
        in_if.InValid   = 1'b1;
        in_if.ALUResult = r;
        in_if.RdAddr    = a;
        in_if.SetFlags  = s;
        in_if.CondCode  = cc;
        {in_if.Negative, in_if.Zero, in_if.Carry, in_if.Overflow} = nzcv;
    endtask

    task automatic idle();
        in_if.InValid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        out_if.OutReady = 1'b0;
        send(32'h0, 5'd0, 1'b0, 4'd0, 4'b0000);
        idle();
        step();
        step();
        chk("rst_outvalid", 32'(out_if.OutValid), 32'd0);
        chk("rst_inready",  32'(in_if.InReady),   32'd0);
        chk("rst_wben",     32'(out_if.WbEnable), 32'd0);
        chk("rst_wbresult", out_if.WbResult,      32'd0);
        chk("rst_wbaddr",   32'(out_if.WbAddr),   32'd0);
        chk("rst_flags",    32'(flags),           32'd0);
        chk("rst_supp",     32'(supp),            32'd0);
        rst_n = 1'b1;
        step();
        chk("rel_inready", 32'(in_if.InReady), 32'd1);

        // single AL op with carry set
        send(32'h0000_00A5, 5'd3, 1'b1, 4'd14, 4'b0010);
        chk("t1_pre_outvalid", 32'(out_if.OutValid), 32'd0);
        step();
        idle();
        chk("t1_outvalid", 32'(out_if.OutValid), 32'd1);
        chk("t1_wben",     32'(out_if.WbEnable), 32'd1);
        chk("t1_wbaddr",   32'(out_if.WbAddr),   32'd3);
        chk("t1_wbresult", out_if.WbResult,      32'h0000_00A5);
        chk("t1_flags_hold", 32'(flags),         32'd0);
        out_if.OutReady = 1'b1;
        step();
        chk("t1_flags",    32'(flags),           32'b0010);
        chk("t1_empty",    32'(out_if.OutValid), 32'd0);

        // flag dependency: EQ after Z-setting op
        send(32'h1, 5'd1, 1'b1, 4'd14, 4'b0100);
        step();
        send(32'h2, 5'd2, 1'b0, 4'd0, 4'b0000);
        step();
        idle();
        chk("t2_eq_addr", 32'(out_if.WbAddr),   32'd2);
        chk("t2_eq_wben", 32'(out_if.WbEnable), 32'd1);
        chk("t2_flags",   32'(flags),           32'b0100);
        step();
        chk("t2_eq_supp", 32'(supp),            32'd0);

        // flag dependency: NE after Z-setting op
        send(32'h1, 5'd1, 1'b1, 4'd14, 4'b0100);
        step();
        send(32'h3, 5'd4, 1'b0, 4'd1, 4'b0000);
        step();
        idle();
        chk("t2_ne_addr", 32'(out_if.WbAddr),   32'd4);
        chk("t2_ne_wben", 32'(out_if.WbEnable), COND ? 32'd0 : 32'd1);
        step();
        chk("t2_ne_supp", 32'(supp),            COND ? 32'd1 : 32'd0);
        chk("t2_ne_empty", 32'(out_if.OutValid), 32'd0);

        // backpressure with three offered ops
        out_if.OutReady = 1'b0;
        send(32'h11, 5'd5, 1'b0, 4'd14, 4'b0000);
        step();
        chk("t3_ready1", 32'(in_if.InReady), 32'd1);
        send(32'h22, 5'd6, 1'b0, 4'd14, 4'b0000);
        step();
        chk("t3_ready2", 32'(in_if.InReady), 32'd0);
        send(32'h33, 5'd7, 1'b0, 4'd14, 4'b0000);
        step();
        chk("t3_held_ready", 32'(in_if.InReady),  32'd0);
        chk("t3_held_head",  out_if.WbResult,     32'h11);
        out_if.OutReady = 1'b1;
        chk("t3_out1", out_if.WbResult, 32'h11);
        step();
        chk("t3_out2", out_if.WbResult, 32'h22);
        chk("t3_ready_back", 32'(in_if.InReady), 32'd1);
        step();
        idle();
        chk("t3_out3", out_if.WbResult, 32'h33);
        chk("t3_out3_addr", 32'(out_if.WbAddr), 32'd7);
        step();
        chk("t3_no_dup", 32'(out_if.OutValid), 32'd0);

        // signed compares against N=1 Z=0 C=0 V=1
        send(32'h4, 5'd11, 1'b1, 4'd14, 4'b1001);
        step();
        send(32'h5, 5'd12, 1'b0, 4'd12, 4'b0000);
        step();
        chk("t4_flags", 32'(flags), 32'b1001);
        chk("t4_gt", 32'(out_if.WbEnable), 32'd1);
        send(32'h6, 5'd13, 1'b0, 4'd11, 4'b0000);
        step();
        chk("t4_lt", 32'(out_if.WbEnable), COND ? 32'd0 : 32'd1);
        send(32'h7, 5'd14, 1'b0, 4'd8, 4'b0000);
        step();
        chk("t4_hi", 32'(out_if.WbEnable), COND ? 32'd0 : 32'd1);
        send(32'h8, 5'd15, 1'b1, 4'd15, 4'b0000);
        step();
        idle();
        chk("t4_nv", 32'(out_if.WbEnable), COND ? 32'd0 : 32'd1);
        step();
        chk("t4_supp",  32'(supp),  COND ? 32'd4 : 32'd0);
        chk("t4_nv_flags", 32'(flags), COND ? 32'b1001 : 32'b0000);

        // reset with two entries queued
        out_if.OutReady = 1'b0;
        send(32'h55, 5'd8, 1'b1, 4'd14, 4'b1111);
        step();
        send(32'h66, 5'd9, 1'b1, 4'd14, 4'b1111);
        step();
        idle();
        chk("t5_full_valid", 32'(out_if.OutValid), 32'd1);
        chk("t5_full_ready", 32'(in_if.InReady),   32'd0);
        rst_n = 1'b0;
        step();
        chk("t5_rst_valid", 32'(out_if.OutValid), 32'd0);
        chk("t5_rst_flags", 32'(flags),           32'd0);
        chk("t5_rst_supp",  32'(supp),            32'd0);
        chk("t5_rst_ready", 32'(in_if.InReady),   32'd0);
        rst_n = 1'b1;
        out_if.OutReady = 1'b1;
        step();
        chk("t5_after_valid", 32'(out_if.OutValid), 32'd0);
        chk("t5_after_ready", 32'(in_if.InReady),   32'd1);
        step();
        chk("t5_after_flags", 32'(flags), 32'd0);

        // NV op: ignored condition in the default build
        out_if.OutReady = 1'b0;
        send(32'h77, 5'd10, 1'b0, 4'd15, 4'b0000);
        step();
        idle();
        chk("t6_nv_wben", 32'(out_if.WbEnable), COND ? 32'd0 : 32'd1);
        out_if.OutReady = 1'b1;
        step();
        chk("t6_nv_supp", 32'(supp), COND ? 32'd1 : 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
